// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//   Registered RV32I/RV64I decode/control stage between fetch and execute.
//   Each accepted instruction is decoded combinationally and the control word
//   is written into a 2-entry skid buffer. The outputs always show the buffer
//   head and read all-zero when the buffer is empty.
//
//   Optional feature: define DECODE_PERF_CNT_EN to build saturating counters
//   of accepted words and accepted illegal words. When it is undefined the
//   counter outputs are tied to zero.
//
// Ports
//   clk_i, cntrst_i        clock, synchronous active-high reset
//   flush_i                drop every buffered entry and the same-cycle input
//   in_valid_i/in_ready_o  input handshake (instr_i, pc_i)
//   out_valid_o/out_ready_i output handshake
//   pc_o                   PC of the head entry
//   I/S/SB/U/UJ_EN_o       immediate-format enables
//   RWR_EN_o               register write enable
//   BE_o/JALRE_o/UJE_o     branch / JALR / JAL redirect enables
//   ALUop_o, sgn_o, arth_o, word_o, illegal_o   ALU control and illegal flag
//   illegal_cnt_o, decoded_cnt_o                performance counters
module decode_ctrl_stage #(
  parameter int XLEN    = 64,
  parameter int PC_W    = 32,
  parameter int ALUOP_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               cntrst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               I_EN_o,
  output logic               S_EN_o,
  output logic               SB_EN_o,
  output logic               U_EN_o,
  output logic               UJ_EN_o,
  output logic               RWR_EN_o,
  output logic               BE_o,
  output logic               JALRE_o,
  output logic               UJE_o,
  output logic [ALUOP_W-1:0] ALUop_o,
  output logic               sgn_o,
  output logic               arth_o,
  output logic               word_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   illegal_cnt_o,
  output logic [CNT_W-1:0]   decoded_cnt_o
);

  localparam bit IS64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPW    = 7'b0111011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [ALUOP_W-1:0] A_ADD  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] A_LINK = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] A_SUB  = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] A_PASS = ALUOP_W'(11);

  typedef struct packed {
    logic               i_en, s_en, sb_en, u_en, uj_en, rwr_en, be, jalre, uje;
    logic [ALUOP_W-1:0] aluop;
    logic               sgn, arth, word, illegal;
  } ctrl_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    ctrl_t           ctrl;
  } entry_t;

  // func3 -> ALUop for register/immediate ALU ops; alt selects SUB/SRA.
  function automatic logic [ALUOP_W-1:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_f3 = alt ? A_SUB : A_ADD;
      3'd1:    alu_f3 = ALUOP_W'(1);
      3'd2:    alu_f3 = ALUOP_W'(2);
      3'd3:    alu_f3 = ALUOP_W'(3);
      3'd4:    alu_f3 = ALUOP_W'(4);
      3'd5:    alu_f3 = alt ? ALUOP_W'(6) : ALUOP_W'(5);
      3'd6:    alu_f3 = ALUOP_W'(7);
      default: alu_f3 = ALUOP_W'(8);
    endcase
  endfunction

  logic [6:0] opc, f7;
  logic [2:0] f3;
  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  // Register specifiers and immediates are not part of the control word.
  logic unused_fields;
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  // Full-width shift func7 check: on RV64 func7[0] is shamt[5].
  logic sh_lo, sh_hi;
  assign sh_lo = IS64 ? (f7[6:1] == 6'b000000) : (f7 == 7'b0000000);
  assign sh_hi = IS64 ? (f7[6:1] == 6'b010000) : (f7 == 7'b0100000);

  ctrl_t dec;
  logic  ill;

  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (opc)
      OPC_LOAD: begin
        dec.i_en   = 1'b1;
        dec.rwr_en = 1'b1;
        dec.aluop  = A_ADD;
        dec.sgn    = (f3 <= 3'd2);
        ill        = (f3 == 3'd7) || (!IS64 && (f3 == 3'd3 || f3 == 3'd6));
      end
      OPC_OPIMM: begin
        dec.i_en   = 1'b1;
        dec.rwr_en = 1'b1;
        dec.arth   = (f3 == 3'd5) && sh_hi;
        dec.aluop  = alu_f3(f3, dec.arth);
        if (f3 == 3'd1)      ill = !sh_lo;
        else if (f3 == 3'd5) ill = !(sh_lo || sh_hi);
      end
      OPC_OPIMMW: begin
        dec.i_en   = 1'b1;
        dec.rwr_en = 1'b1;
        dec.word   = 1'b1;
        dec.arth   = (f3 == 3'd5) && (f7 == 7'b0100000);
        dec.aluop  = alu_f3(f3, dec.arth);
        // W shifts have a 5-bit shamt, so func7 is checked in full.
        case (f3)
          3'd0:    ill = !IS64;
          3'd1:    ill = !IS64 || (f7 != 7'b0000000);
          3'd5:    ill = !IS64 || !(f7 == 7'b0000000 || f7 == 7'b0100000);
          default: ill = 1'b1;
        endcase
      end
      OPC_OP, OPC_OPW: begin
        dec.rwr_en = 1'b1;
        dec.word   = (opc == OPC_OPW);
        dec.arth   = (f7 == 7'b0100000);
        dec.aluop  = alu_f3(f3, dec.arth);
        if (f7 == 7'b0000000)      ill = 1'b0;
        else if (dec.arth)         ill = !(f3 == 3'd0 || f3 == 3'd5);
        else                       ill = 1'b1;
        if (opc == OPC_OPW && !(IS64 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)))
          ill = 1'b1;
      end
      OPC_STORE: begin
        dec.s_en  = 1'b1;
        dec.aluop = A_ADD;
        ill       = (f3 > 3'd3) || (!IS64 && f3 == 3'd3);
      end
      OPC_BRANCH: begin
        dec.sb_en = 1'b1;
        dec.be    = 1'b1;
        dec.aluop = A_SUB;
        dec.sgn   = (f3 == 3'd4) || (f3 == 3'd5);
        ill       = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_LUI: begin
        dec.u_en   = 1'b1;
        dec.rwr_en = 1'b1;
        dec.aluop  = A_PASS;
      end
      OPC_AUIPC: begin
        dec.u_en   = 1'b1;
        dec.rwr_en = 1'b1;
        dec.aluop  = A_ADD;
      end
      OPC_JAL: begin
        dec.uj_en  = 1'b1;
        dec.uje    = 1'b1;
        dec.rwr_en = 1'b1;
        dec.aluop  = A_LINK;
      end
      OPC_JALR: begin
        dec.i_en   = 1'b1;
        dec.jalre  = 1'b1;
        dec.rwr_en = 1'b1;
        dec.aluop  = A_LINK;
        ill        = (f3 != 3'd0);
      end
      default: ill = 1'b1;
    endcase
    // Illegal words carry only the illegal flag.
    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // 2-entry skid buffer, ent[0] is the head.
  entry_t     ent [2];
  logic [1:0] cnt;
  logic       push, pop, wr_idx;

  assign in_ready_o  = (cnt != 2'd2);
  assign out_valid_o = (cnt != 2'd0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i;
  // Slot for the new entry after any same-cycle shift of the head.
  assign wr_idx      = pop ? (cnt == 2'd2) : cnt[0];

  always_ff @(posedge clk_i) begin
    if (cntrst_i) begin
      cnt    <= 2'd0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else if (flush_i) begin
      cnt <= 2'd0;
    end else begin
      if (pop)  ent[0] <= ent[1];
      if (push) ent[wr_idx] <= '{pc: pc_i, ctrl: dec};
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

  entry_t head;
  assign head = out_valid_o ? ent[0] : '0;

  assign pc_o      = head.pc;
  assign I_EN_o    = head.ctrl.i_en;
  assign S_EN_o    = head.ctrl.s_en;
  assign SB_EN_o   = head.ctrl.sb_en;
  assign U_EN_o    = head.ctrl.u_en;
  assign UJ_EN_o   = head.ctrl.uj_en;
  assign RWR_EN_o  = head.ctrl.rwr_en;
  assign BE_o      = head.ctrl.be;
  assign JALRE_o   = head.ctrl.jalre;
  assign UJE_o     = head.ctrl.uje;
  assign ALUop_o   = head.ctrl.aluop;
  assign sgn_o     = head.ctrl.sgn;
  assign arth_o    = head.ctrl.arth;
  assign word_o    = head.ctrl.word;
  assign illegal_o = head.ctrl.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] ill_cnt, dec_cnt;

  // Saturating; only reset clears them, flush does not.
  always_ff @(posedge clk_i) begin
    if (cntrst_i) begin
      ill_cnt <= '0;
      dec_cnt <= '0;
    end else if (push) begin
      if (dec_cnt != '1)                 dec_cnt <= dec_cnt + 1'b1;
      if (dec.illegal && ill_cnt != '1)  ill_cnt <= ill_cnt + 1'b1;
    end
  end

  assign illegal_cnt_o = ill_cnt;
  assign decoded_cnt_o = dec_cnt;
`else
  assign illegal_cnt_o = '0;
  assign decoded_cnt_o = '0;
`endif

endmodule

// File: tb/tb_decode_ctrl_stage.sv
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr, pc;

  // XLEN=64 instance (CNT_W=2 for the saturation case)
  logic        in_ready, out_valid;
  logic [31:0] pc_o;
  logic        i_en, s_en, sb_en, u_en, uj_en, rwr_en, be, jalre, uje, sgn, arth, word, illegal;
  logic [5:0]  aluop;
  logic [1:0]  ill_cnt, dec_cnt;

  // XLEN=32 instance, same stimulus
  logic        in_ready32, out_valid32;
  logic [31:0] pc_o32;
  logic        i_en32, s_en32, sb_en32, u_en32, uj_en32, rwr_en32, be32, jalre32, uje32;
  logic        sgn32, arth32, word32, illegal32;
  logic [5:0]  aluop32;
  logic [15:0] unused_ill32, unused_dec32;

  wire [12:0] fl64 = {i_en, s_en, sb_en, u_en, uj_en, rwr_en, be, jalre, uje, sgn, arth, word, illegal};
  wire [12:0] fl32 = {i_en32, s_en32, sb_en32, u_en32, uj_en32, rwr_en32, be32, jalre32, uje32,
                      sgn32, arth32, word32, illegal32};

`ifdef DECODE_PERF_CNT_EN
  localparam logic [1:0] EXP_DEC5 = 2'd3, EXP_ILL5 = 2'd1, EXP_ILL_END = 2'd2;
`else
  localparam logic [1:0] EXP_DEC5 = 2'd0, EXP_ILL5 = 2'd0, EXP_ILL_END = 2'd0;
`endif

  decode_ctrl_stage #(.XLEN(64), .PC_W(32), .ALUOP_W(6), .CNT_W(2)) dut64 (
    .clk_i(clk), .cntrst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_o),
    .I_EN_o(i_en), .S_EN_o(s_en), .SB_EN_o(sb_en), .U_EN_o(u_en), .UJ_EN_o(uj_en),
    .RWR_EN_o(rwr_en), .BE_o(be), .JALRE_o(jalre), .UJE_o(uje), .ALUop_o(aluop),
    .sgn_o(sgn), .arth_o(arth), .word_o(word), .illegal_o(illegal),
    .illegal_cnt_o(ill_cnt), .decoded_cnt_o(dec_cnt));

  decode_ctrl_stage #(.XLEN(32), .PC_W(32), .ALUOP_W(6), .CNT_W(16)) dut32 (
    .clk_i(clk), .cntrst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid32), .out_ready_i(out_ready), .pc_o(pc_o32),
    .I_EN_o(i_en32), .S_EN_o(s_en32), .SB_EN_o(sb_en32), .U_EN_o(u_en32), .UJ_EN_o(uj_en32),
    .RWR_EN_o(rwr_en32), .BE_o(be32), .JALRE_o(jalre32), .UJE_o(uje32), .ALUop_o(aluop32),
    .sgn_o(sgn32), .arth_o(arth32), .word_o(word32), .illegal_o(illegal32),
    .illegal_cnt_o(unused_ill32), .decoded_cnt_o(unused_dec32));

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] p);
    instr    = w;
    pc       = p;
    in_valid = 1'b1;
    tick();
  endtask

  // flag order: i s sb u uj rwr be jalre uje sgn arth word illegal
  task automatic exp64(input string tag, input logic [12:0] fl, input logic [5:0] op,
                       input logic [31:0] p);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_fl"},  fl64, fl);
    chk({tag, "_alu"}, aluop, op);
    chk({tag, "_pc"},  pc_o, p);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0;
    tick(); tick();
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_fl", fl64, 13'h0);
    chk("rst_alu", aluop, 6'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_dcnt", dec_cnt, 2'd0);
    chk("rst_icnt", ill_cnt, 2'd0);
    rst = 1'b0;

    // streaming decode, out_ready=1: each word is on the outputs one cycle later
    send(32'h00500093, 32'h100); exp64("addi",  13'h1080, 6'd0,  32'h100);
    send(32'h402081B3, 32'h104); exp64("sub",   13'h0084, 6'd10, 32'h104);
    send(32'h4032D293, 32'h108); exp64("srai",  13'h1084, 6'd6,  32'h108);
    send(32'h00000000, 32'h10C); exp64("zero",  13'h0001, 6'd0,  32'h10C);
    send(32'h0010809B, 32'h110); exp64("addiw", 13'h1082, 6'd0,  32'h110);
    chk("addiw32_vld", out_valid32, 1'b1);
    chk("addiw32_fl", fl32, 13'h0001);
    chk("addiw32_alu", aluop32, 6'd0);
    chk("addiw32_pc", pc_o32, 32'h110);
    chk("cnt5_dec", dec_cnt, EXP_DEC5);
    chk("cnt5_ill", ill_cnt, EXP_ILL5);
    send(32'h123450B7, 32'h114); exp64("lui",   13'h0280, 6'd11, 32'h114);
    send(32'h0020C463, 32'h118); exp64("blt",   13'h0448, 6'd10, 32'h118);
    send(32'h008000EF, 32'h11C); exp64("jal",   13'h0190, 6'd9,  32'h11C);
    send(32'h000080E7, 32'h120); exp64("jalr",  13'h10A0, 6'd9,  32'h120);
    send(32'h0020A223, 32'h124); exp64("sw",    13'h0800, 6'd0,  32'h124);
    send(32'h00001097, 32'h128); exp64("auipc", 13'h0280, 6'd0,  32'h128);
    send(32'h0000B103, 32'h12C); exp64("ld",    13'h1080, 6'd0,  32'h12C);
    chk("ld32_fl", fl32, 13'h0001);
    send(32'h02009093, 32'h130); exp64("slli32", 13'h1080, 6'd1, 32'h130);
    chk("slli32_rv32_fl", fl32, 13'h0001);
    send(32'h0020A063, 32'h134); exp64("bf3_2", 13'h0001, 6'd0,  32'h134);
    in_valid = 1'b0;
    tick();
    chk("empty_vld", out_valid, 1'b0);
    chk("empty_fl", fl64, 13'h0);
    chk("empty_pc", pc_o, 32'h0);

    // back-pressure: 3 words pushed, only 2 fit
    out_ready = 1'b0;
    send(32'h00500093, 32'h200);
    chk("bp1_rdy", in_ready, 1'b1);
    send(32'h402081B3, 32'h204);
    chk("bp2_rdy", in_ready, 1'b0);
    exp64("bp2_head", 13'h1080, 6'd0, 32'h200);
    send(32'h008000EF, 32'h208);
    chk("bp3_rdy", in_ready, 1'b0);
    exp64("bp3_hold", 13'h1080, 6'd0, 32'h200);
    out_ready = 1'b1;
    tick();
    exp64("bp_w2", 13'h0084, 6'd10, 32'h204);
    chk("bp_w2_rdy", in_ready, 1'b1);
    tick();
    exp64("bp_w3", 13'h0190, 6'd9, 32'h208);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_vld", out_valid, 1'b0);

    // flush at occupancy 2 with a valid input
    out_ready = 1'b0;
    send(32'h00500093, 32'h300);
    send(32'h402081B3, 32'h304);
    chk("fl_full_rdy", in_ready, 1'b0);
    instr = 32'h123450B7; pc = 32'h308; in_valid = 1'b1; flush = 1'b1;
    tick();
    chk("fl_vld", out_valid, 1'b0);
    chk("fl_rdy", in_ready, 1'b1);
    chk("fl_pc", pc_o, 32'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_drop_vld", out_valid, 1'b0);
    chk("end_ill_cnt", ill_cnt, EXP_ILL_END);

    // reset during activity overrides flush and buffered data
    out_ready = 1'b0;
    send(32'h00500093, 32'h400);
    chk("mr_pre_vld", out_valid, 1'b1);
    rst = 1'b1; flush = 1'b1;
    tick();
    chk("mr_vld", out_valid, 1'b0);
    chk("mr_rdy", in_ready, 1'b1);
    chk("mr_pc", pc_o, 32'h0);
    chk("mr_dcnt", dec_cnt, 2'd0);
    chk("mr_icnt", ill_cnt, 2'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("mr_post_vld", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
